// File: rtl/ipv4_rx.sv
// rtl/ipv4_rx.sv - IPv4 receive header parser on a nibble stream
// Validates the header and checksum, captures addresses and forwards the TCP segment nibbles.
module ipv4_rx #(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_0164
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [3:0]  din,
  output logic        dout_valid,
  output logic [3:0]  dout,
  output logic        hdr_done,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic [15:0] payload_len,
  output logic        done,
  output logic [2:0]  err
);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HEADER, S_PAYLOAD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  lo_q, lo_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] csum_q, csum_d;
  logic [2:0]  err_lat_q, err_lat_d;
  logic        dout_valid_q, dout_valid_d;
  logic [3:0]  dout_q, dout_d;
  logic        hdr_done_q, hdr_done_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] payload_len_q, payload_len_d;
  logic        done_q, done_d;
  logic [2:0]  err_q, err_d;

  logic [7:0]  byte_w;
  logic [15:0] word_w;
  logic [16:0] sum17;
  logic [15:0] csum_add;
  logic [13:0] word_idx;
  logic [14:0] byte_idx;
  logic [3:0]  ihl_m1;
  logic        last_hdr;
  logic [31:0] dst_cur;
  logic [15:0] hdr_bytes;
  logic        below_limit;

  // Ones'-complement add with the end-around carry folded back immediately.
  assign byte_w      = {din, lo_q};
  assign word_w      = {hi_byte_q, byte_w};
  assign sum17       = {1'b0, csum_q} + {1'b0, word_w};
  assign csum_add    = sum17[15:0] + {15'd0, sum17[16]};
  assign word_idx    = cnt_q[15:2];
  assign byte_idx    = cnt_q[15:1];
  assign ihl_m1      = ihl_q - 4'd1;
  assign last_hdr    = (cnt_q == {9'd0, ihl_m1, 3'b111});
  // With IHL = 5 the low half of dst arrives on the very last header nibble.
  assign dst_cur     = (word_idx == 14'd9) ? {dst_q[31:16], word_w} : dst_q;
  assign hdr_bytes   = {10'd0, ihl_q, 2'b00};
  assign below_limit = ({1'b0, cnt_q} < {tot_len_q, 1'b0});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lo_d          = lo_q;
    hi_byte_d     = hi_byte_q;
    ihl_d         = ihl_q;
    tot_len_d     = tot_len_q;
    proto_d       = proto_q;
    src_d         = src_q;
    dst_d         = dst_q;
    csum_d        = csum_q;
    err_lat_d     = err_lat_q;
    src_ip_d      = src_ip_q;
    dst_ip_d      = dst_ip_q;
    payload_len_d = payload_len_q;
    dout_valid_d  = 1'b0;
    dout_d        = 4'h0;
    hdr_done_d    = 1'b0;
    done_d        = 1'b0;
    err_d         = 3'd0;

    case (state_q)
      S_SYNC: begin
        if (!valid) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (valid) begin
          state_d   = S_HEADER;
          cnt_d     = 16'd1;
          lo_d      = din;
          csum_d    = 16'h0000;
          err_lat_d = 3'd0;
        end
      end
      S_HEADER: begin
        if (!valid) begin
          done_d  = 1'b1;
          err_d   = 3'd5;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (!cnt_q[0]) begin
            lo_d = din;
          end else begin
            if (byte_idx == 15'd9) proto_d = byte_w;
            if (!byte_idx[0]) begin
              hi_byte_d = byte_w;
            end else begin
              csum_d = csum_add;
              case (word_idx)
                14'd1:   tot_len_d       = word_w;
                14'd6:   src_d[31:16]    = word_w;
                14'd7:   src_d[15:0]     = word_w;
                14'd8:   dst_d[31:16]    = word_w;
                14'd9:   dst_d[15:0]     = word_w;
                default: ;
              endcase
              if (last_hdr) begin
                state_d = S_DROP;
                if (tot_len_q < hdr_bytes)   err_lat_d = 3'd1;
                else if (csum_add != 16'hFFFF) err_lat_d = 3'd2;
                else if (proto_q != 8'd6)    err_lat_d = 3'd3;
                else if (dst_cur != LOCAL_IP) err_lat_d = 3'd4;
                else begin
                  state_d       = S_PAYLOAD;
                  hdr_done_d    = 1'b1;
                  src_ip_d      = src_q;
                  dst_ip_d      = dst_cur;
                  payload_len_d = tot_len_q - hdr_bytes;
                end
              end
            end
            if (byte_idx == 15'd0) begin
              ihl_d = lo_q;
              if (din != 4'd4 || lo_q < 4'd5) begin
                err_lat_d = 3'd1;
                state_d   = S_DROP;
              end
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!valid) begin
          done_d  = 1'b1;
          err_d   = below_limit ? 3'd5 : 3'd0;
          state_d = S_IDLE;
        end else begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (below_limit) begin
            dout_valid_d = 1'b1;
            dout_d       = din;
          end
        end
      end
      S_DROP: begin
        if (!valid) begin
          done_d  = 1'b1;
          err_d   = err_lat_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_SYNC;
      cnt_q         <= 16'd0;
      lo_q          <= 4'h0;
      hi_byte_q     <= 8'h00;
      ihl_q         <= 4'h0;
      tot_len_q     <= 16'd0;
      proto_q       <= 8'h00;
      src_q         <= 32'd0;
      dst_q         <= 32'd0;
      csum_q        <= 16'd0;
      err_lat_q     <= 3'd0;
      dout_valid_q  <= 1'b0;
      dout_q        <= 4'h0;
      hdr_done_q    <= 1'b0;
      src_ip_q      <= 32'd0;
      dst_ip_q      <= 32'd0;
      payload_len_q <= 16'd0;
      done_q        <= 1'b0;
      err_q         <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
      hi_byte_q     <= hi_byte_d;
      ihl_q         <= ihl_d;
      tot_len_q     <= tot_len_d;
      proto_q       <= proto_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      csum_q        <= csum_d;
      err_lat_q     <= err_lat_d;
      dout_valid_q  <= dout_valid_d;
      dout_q        <= dout_d;
      hdr_done_q    <= hdr_done_d;
      src_ip_q      <= src_ip_d;
      dst_ip_q      <= dst_ip_d;
      payload_len_q <= payload_len_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign dout_valid  = dout_valid_q;
  assign dout        = dout_q;
  assign hdr_done    = hdr_done_q;
  assign src_ip      = src_ip_q;
  assign dst_ip      = dst_ip_q;
  assign payload_len = payload_len_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ipv4_rx.sv
// tb/tb_ipv4_rx.sv - directed self-checking bench for ipv4_rx
// Builds IPv4 frames as byte queues, streams them as nibbles and scoreboards the outputs.
module tb_ipv4_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  din = 4'h0;
  logic        dout_valid;
  logic [3:0]  dout;
  logic        hdr_done;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] payload_len;
  logic        done;
  logic [2:0]  err;

  localparam logic [31:0] SRC = 32'h0A00_0001;
  localparam logic [31:0] ME  = 32'hC0A8_0164;

  ipv4_rx #(.LOCAL_IP(ME)) dut (
    .clk(clk), .rst(rst), .valid(valid), .din(din),
    .dout_valid(dout_valid), .dout(dout), .hdr_done(hdr_done),
    .src_ip(src_ip), .dst_ip(dst_ip), .payload_len(payload_len),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] frame[$];
  logic [3:0] got[$];
  logic [3:0] exp_nib[$];
  logic [2:0] errs[$];
  int         nib_cyc[$];
  int         hdr_n;
  int         hdr_cyc;
  int         first_dv;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid) begin
      got.push_back(dout);
      if (first_dv < 0) first_dv = cyc;
    end
    if (hdr_done) begin
      hdr_n++;
      hdr_cyc = cyc;
    end
    if (done) errs.push_back(err);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    got.delete();
    errs.delete();
    nib_cyc.delete();
    hdr_n    = 0;
    hdr_cyc  = -1;
    first_dv = -1;
  endtask

  function automatic logic [15:0] ones_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i += 2) s += {frame[i], frame[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic build(input logic [7:0] vihl, input logic [15:0] tlen, input logic [7:0] proto,
                       input logic [31:0] dst, input int nopt, input int npay, input int npad,
                       input bit bad_ck);
    logic [15:0] c;
    frame.delete();
    frame.push_back(vihl);         frame.push_back(8'h00);
    frame.push_back(tlen[15:8]);   frame.push_back(tlen[7:0]);
    frame.push_back(8'h1c);        frame.push_back(8'h46);
    frame.push_back(8'h40);        frame.push_back(8'h00);
    frame.push_back(8'h40);        frame.push_back(proto);
    frame.push_back(8'h00);        frame.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frame.push_back(SRC[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frame.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < nopt; i++) frame.push_back(8'hA0 + 8'(i));
    c = ~ones_sum(20 + nopt);
    frame[10] = c[15:8];
    frame[11] = c[7:0] ^ {7'd0, bad_ck};
    for (int i = 0; i < npay; i++) frame.push_back(8'((i * 37 + 5) & 255));
    for (int i = 0; i < npad; i++) frame.push_back(8'h00);
  endtask

  task automatic send_nibble(input logic [3:0] n);
    valid = 1'b1;
    din   = n;
    @(posedge clk);
    #1;
    nib_cyc.push_back(cyc);
  endtask

  task automatic send_bytes(input int first, input int last);
    for (int i = first; i < last; i++) begin
      send_nibble(frame[i][3:0]);
      send_nibble(frame[i][7:4]);
    end
  endtask

  task automatic end_frame(input int idle);
    valid = 1'b0;
    din   = 4'h0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp_fwd(input string tag, input int hl, input int tlen, input int nsent);
    int bad = 0;
    exp_nib.delete();
    for (int i = hl; i < tlen && i < nsent; i++) begin
      exp_nib.push_back(frame[i][3:0]);
      exp_nib.push_back(frame[i][7:4]);
    end
    check({tag, "_fwd_count"}, got.size(), exp_nib.size());
    for (int i = 0; i < got.size() && i < exp_nib.size(); i++)
      if (got[i] !== exp_nib[i]) bad++;
    check({tag, "_fwd_data"}, bad, 0);
  endtask

  task automatic run_bad(input string tag, input logic [7:0] vihl, input logic [7:0] proto,
                         input logic [31:0] dst, input bit bad_ck, input logic [2:0] exp_err);
    clear_stats();
    build(vihl, 16'd44, proto, dst, 0, 24, 2, bad_ck);
    send_bytes(0, 46);
    end_frame(4);
    check({tag, "_hdr_done"}, hdr_n, 0);
    check({tag, "_dout_valid"}, got.size(), 0);
    check({tag, "_done_count"}, errs.size(), 1);
    check({tag, "_err"}, errs.size() > 0 ? errs[0] : 3'd7, exp_err);
    check({tag, "_len_hold"}, payload_len, 16'd24);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {dout_valid, dout, hdr_done, done, err}, 0);
    check("rst_regs", {src_ip, dst_ip, payload_len}, 0);
    rst = 1'b0;
    end_frame(2);

    // Good frame: 24 payload bytes plus 2 pad bytes.
    clear_stats();
    build(8'h45, 16'd44, 8'h06, ME, 0, 24, 2, 1'b0);
    send_bytes(0, 46);
    end_frame(4);
    cmp_fwd("good", 20, 44, 46);
    check("good_hdr_count", hdr_n, 1);
    check("good_hdr_cycle", hdr_cyc, nib_cyc[39]);
    check("good_first_dv", first_dv, nib_cyc[40]);
    check("good_payload_len", payload_len, 16'd24);
    check("good_src", src_ip, SRC);
    check("good_dst", dst_ip, ME);
    check("good_done_count", errs.size(), 1);
    check("good_err", errs.size() > 0 ? errs[0] : 3'd7, 3'd0);

    run_bad("cksum", 8'h45, 8'h06, ME, 1'b1, 3'd2);
    run_bad("proto", 8'h45, 8'h11, ME, 1'b0, 3'd3);
    run_bad("dst", 8'h45, 8'h06, 32'hC0A8_0165, 1'b0, 3'd4);
    run_bad("version", 8'h65, 8'h06, ME, 1'b0, 3'd1);

    // IHL 6 with four option bytes.
    clear_stats();
    build(8'h46, 16'd40, 8'h06, ME, 4, 16, 0, 1'b0);
    send_bytes(0, 40);
    end_frame(4);
    cmp_fwd("opts", 24, 40, 40);
    check("opts_first_dv", first_dv, nib_cyc[48]);
    check("opts_payload_len", payload_len, 16'd16);
    check("opts_err", errs.size() > 0 ? errs[0] : 3'd7, 3'd0);

    // Total length 60 but only 40 bytes delivered.
    clear_stats();
    build(8'h45, 16'd60, 8'h06, ME, 0, 20, 0, 1'b0);
    send_bytes(0, 40);
    end_frame(4);
    cmp_fwd("trunc", 20, 60, 40);
    check("trunc_err", errs.size() > 0 ? errs[0] : 3'd7, 3'd5);

    // Frame ends inside the header.
    clear_stats();
    build(8'h45, 16'd44, 8'h06, ME, 0, 24, 0, 1'b0);
    send_bytes(0, 10);
    end_frame(4);
    check("short_hdr_done", hdr_n, 0);
    check("short_err", errs.size() > 0 ? errs[0] : 3'd7, 3'd5);

    // Header only: total length equals the header size.
    clear_stats();
    build(8'h45, 16'd20, 8'h06, ME, 0, 0, 6, 1'b0);
    send_bytes(0, 26);
    end_frame(4);
    check("empty_hdr_done", hdr_n, 1);
    check("empty_payload_len", payload_len, 16'd0);
    check("empty_dout_valid", got.size(), 0);
    check("empty_err", errs.size() > 0 ? errs[0] : 3'd7, 3'd0);

    // Reset in the middle of the payload with valid still high.
    build(8'h45, 16'd44, 8'h06, ME, 0, 24, 2, 1'b0);
    send_bytes(0, 30);
    clear_stats();
    rst = 1'b1;
    #1;
    check("midrst_outputs", {dout_valid, dout, hdr_done, done, err}, 0);
    check("midrst_regs", {src_ip, dst_ip, payload_len}, 0);
    send_bytes(30, 32);
    rst = 1'b0;
    send_bytes(32, 46);
    end_frame(4);
    check("midrst_no_fwd", got.size(), 0);
    check("midrst_no_done", errs.size(), 0);

    // Two good frames separated by a single idle cycle.
    clear_stats();
    send_bytes(0, 46);
    end_frame(1);
    send_bytes(0, 46);
    end_frame(4);
    check("b2b_hdr_count", hdr_n, 2);
    check("b2b_fwd_count", got.size(), 96);
    check("b2b_done_count", errs.size(), 2);
    check("b2b_err0", errs.size() > 0 ? errs[0] : 3'd7, 3'd0);
    check("b2b_err1", errs.size() > 1 ? errs[1] : 3'd7, 3'd0);
    check("b2b_payload_len", payload_len, 16'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ipv4_rx.md
# ipv4_rx

Receive-side IPv4 header parser. It takes the nibble stream produced by the Ethernet receive path (ethertype 0x0800 already matched), assembles bytes, validates the IPv4 header and its checksum, and captures the source/destination addresses and payload length. It forwards only the TCP segment nibbles, unchanged and in order, to the downstream TCP decoder using the same `valid`/4-bit-data convention. It also reports one completion status per frame.

## Interface
- `LOCAL_IP`, 32'hC0A8_0164, destination address accepted (192.168.1.100).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `valid`  in  1  nibble strobe; high for every nibble of one IP datagram (plus any Ethernet padding), contiguous; low for ≥1 cycle between frames.
- `din`  in  4  data nibble; each byte arrives low nibble first.
- `dout_valid`  out  1  TCP segment nibble strobe to the TCP decoder.
- `dout`  out  4  TCP segment nibble.
- `hdr_done`  out  1  one-cycle pulse: header accepted, payload follows.
- `src_ip`  out  32  source address of the last accepted header.
- `dst_ip`  out  32  destination address of the last accepted header.
- `payload_len`  out  16  bytes of TCP segment (total length − IHL·4).
- `done`  out  1  one-cycle end-of-frame pulse.
- `err`  out  3  status, valid with `done`: 0 ok, 1 bad version/IHL/length, 2 bad checksum, 3 protocol ≠ 6, 4 dst ≠ LOCAL_IP, 5 truncated.

## Operation
- Byte assembly: byte = {second nibble, first nibble}. A 16-bit word = {even byte, odd byte} (network order).
- Nibble counter: 16 bits, reset to 0 at the start of each frame (first cycle with `valid` high after `valid` low).
- States:
  - SYNC: entered on reset. Waits for `valid` = 0, then goes to IDLE. Emits no pulses.
  - IDLE: first `valid` nibble → HEADER, counter = 1.
  - HEADER:
    - Byte 0 complete: version must be 4 and IHL ≥ 5, else latch err = 1 → DROP.
    - Bytes 2–3: capture total length. Byte 9: protocol. Bytes 12–15: src. Bytes 16–19: dst. Option bytes are summed, not stored.
    - Last header nibble (index IHL·8−1): evaluate checks in priority order — total length < IHL·4 (1), checksum (2), protocol (3), dst (4).
    - All pass → PAYLOAD with `hdr_done` pulse; otherwise → DROP with the first failure latched.
  - PAYLOAD: forward nibbles with index < total_len·2. Later nibbles (padding) are ignored.
  - DROP: ignore input until `valid` falls.
- Frame end: on the first cycle with `valid` = 0 after a frame, pulse `done` and return to IDLE.
  - From PAYLOAD: err = 5 if fewer than total_len·2 nibbles were received, else 0.
  - From HEADER (frame shorter than header): err = 5.
- Checksum: ones'-complement sum over all IHL·2 header words. 17-bit accumulator with end-around carry folded on every add. Pass iff the final 16-bit value = 16'hFFFF.
- `src_ip`, `dst_ip`, `payload_len` update only on `hdr_done` and hold until the next `hdr_done`.

## Timing
- Reset values: all outputs 0; state SYNC.
- `dout`/`dout_valid`: registered copy of `din`/forward condition, 1-cycle latency, no gaps introduced.
- `hdr_done`: asserted in the cycle after the last header nibble is sampled, which is the same cycle `dout_valid` could first be high for a 0-byte-header-delay case. The first payload nibble is sampled one cycle later, so `hdr_done` precedes the first `dout_valid` by exactly 1 cycle.
- `done`/`err`: asserted the cycle after `valid` is first seen low. `err` returns to 0 with `done`.
- One idle cycle between frames is sufficient. A new frame starting in the same cycle as `done` is accepted.
- Reset mid-frame: outputs cleared immediately; no `done` for the aborted frame. The remainder of that frame is discarded via SYNC.
- Total length = IHL·4: `hdr_done` pulses, `payload_len` = 0, no `dout_valid`, err = 0.

## Test plan
- Good frame: 45 00 00 2C …, proto 06, dst C0A80164, correct checksum, 24 payload bytes + 2 pad bytes → 48 `dout_valid` nibbles matching input at +1 cycle, `hdr_done` ×1, `payload_len` = 24, `done` with err = 0.
- Same frame with one checksum bit flipped → no `hdr_done`, no `dout_valid`, err = 2. Proto 0x11 → err = 3. dst C0A80165 → err = 4. First byte 0x65 → err = 1.
- IHL = 6, 4 option bytes, total length 40 → first `dout_valid` follows input nibble 48, `payload_len` = 16, checksum includes options, err = 0.
- Total length 60, `valid` drops after 40 bytes → 40 payload nibbles forwarded, err = 5.
- Assert `rst` mid-payload with `valid` held high → outputs 0, nothing forwarded until `valid` low. The next good frame decodes correctly; two good frames separated by 1 idle cycle give two `done` pulses, err = 0.
